// File: rtl/io_bus_master.sv
// io_bus_master
//   Queues IO read/write commands in a small FIFO and replays them one at a
//   time onto a simple strobed IO bus. Reads wait READ_LATENCY cycles after
//   the strobe, capture io_read_value and present it on a valid/ready
//   response port. While a response is pending, no further IO strobe issues.
//
// Parameters
//   FIFO_DEPTH    command FIFO entries (power of two, 2..16)
//   READ_LATENCY  cycles from io_read_en to io_read_value valid (0..3)
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write/cmd_address/cmd_wdata command fields (1 = write)
//   rsp_valid/rsp_ready/rsp_data    read response handshake and data
//   busy                            FIFO non-empty or a command in flight
//   io_address/io_write_value       registered IO bus address/write data
//   io_write_en/io_read_en          one-cycle IO strobes
//   io_read_value                   responder read data
module io_bus_master #(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_address,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic [15:0] io_address,
  output logic [15:0] io_write_value,
  output logic        io_write_en,
  output logic        io_read_en,
  input  logic [15:0] io_read_value
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam int LAT_INIT = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READ, RESPOND} state_t;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  state_t state_q, state_d;

  cmd_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic push, pop, empty, full;
  cmd_t in_cmd, head;

  logic [15:0] io_address_q, io_address_d;
  logic [15:0] io_write_value_q, io_write_value_d;
  logic        io_write_en_q, io_write_en_d;
  logic        io_read_en_q, io_read_en_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [1:0]  lat_q, lat_d;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  // cmd_ready is purely registered: a pop in a full cycle does not reopen it.
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign in_cmd    = '{write: cmd_write, addr: cmd_address, wdata: cmd_wdata};

  // When the FIFO is empty the incoming command bypasses storage so that an
  // idle master can strobe it in the cycle right after the accept edge. The
  // push still advances both pointers, which keeps the count unchanged.
  assign head = empty ? in_cmd : mem_q[rd_ptr_q];
  assign pop  = (state_q == IDLE) && (!empty || push);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d          = state_q;
    io_address_d     = io_address_q;
    io_write_value_d = io_write_value_q;
    io_write_en_d    = 1'b0;
    io_read_en_d     = 1'b0;
    rsp_valid_d      = rsp_valid_q;
    rsp_data_d       = rsp_data_q;
    lat_d            = lat_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          io_address_d = head.addr;
          if (head.write) begin
            io_write_value_d = head.wdata;
            io_write_en_d    = 1'b1;
          end else begin
            io_read_en_d = 1'b1;
          end
          lat_d   = 2'(LAT_INIT);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Exactly one strobe is high here; it tells us the command type.
        if (io_read_en_q) begin
          if (READ_LATENCY == 0) begin
            rsp_data_d  = io_read_value;
            rsp_valid_d = 1'b1;
            state_d     = RESPOND;
          end else begin
            state_d = WAIT_READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_READ: begin
        if (lat_q == 2'd0) begin
          rsp_data_d  = io_read_value;
          rsp_valid_d = 1'b1;
          state_d     = RESPOND;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      io_address_q     <= '0;
      io_write_value_q <= '0;
      io_write_en_q    <= 1'b0;
      io_read_en_q     <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= '0;
      lat_q            <= '0;
    end else begin
      state_q          <= state_d;
      io_address_q     <= io_address_d;
      io_write_value_q <= io_write_value_d;
      io_write_en_q    <= io_write_en_d;
      io_read_en_q     <= io_read_en_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
      lat_q            <= lat_d;
    end
  end

  assign io_address     = io_address_q;
  assign io_write_value = io_write_value_q;
  assign io_write_en    = io_write_en_q;
  assign io_read_en     = io_read_en_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign busy           = !empty || (state_q != IDLE);

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter READ_LATENCY, default 0, meaning cycles from io_read_en high to io_read_value valid (0..3).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1, meaning a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1, meaning the FIFO can accept a command.
REQ-007 SHALL have port cmd_write, input, 1, meaning 1 = write and 0 = read.
REQ-008 SHALL have port cmd_address, input, 16, meaning the IO address.
REQ-009 SHALL have port cmd_wdata, input, 16, meaning write data, ignored for reads.
REQ-010 SHALL have port rsp_valid, output, 1, meaning read data is available.
REQ-011 SHALL have port rsp_ready, input, 1, meaning the consumer takes the read data.
REQ-012 SHALL have port rsp_data, output, 16, meaning captured read data.
REQ-013 SHALL have port busy, output, 1, meaning the FIFO is non-empty or the FSM is not IDLE.
REQ-014 SHALL have port io_address, output, 16, meaning the IO bus address.
REQ-015 SHALL have port io_write_value, output, 16, meaning IO bus write data.
REQ-016 SHALL have port io_write_en, output, 1, meaning a one-cycle write strobe.
REQ-017 SHALL have port io_read_en, output, 1, meaning a one-cycle read strobe.
REQ-018 SHALL have port io_read_value, input, 16, meaning responder read data.

Function
REQ-019 SHALL accept a command on any edge where cmd_valid && cmd_ready, pushing {write, address, wdata} into the FIFO.
REQ-020 SHALL drive cmd_ready = !full; cmd_ready SHALL stay low when full, even if a pop occurs in the same cycle.
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT_READ, RESPOND.
REQ-022 In IDLE with the FIFO non-empty, SHALL pop the head, register io_address/io_write_value from it, raise the matching strobe, and go to ISSUE; the strobe is visible the cycle after the accept edge at the earliest.
REQ-023 Strobes SHALL be high for exactly one cycle; io_write_en and io_read_en SHALL never be high together.
REQ-024 ISSUE for a write SHALL return to IDLE; back-to-back writes SHALL produce one strobe every 2 cycles.
REQ-025 ISSUE for a read SHALL go to WAIT_READ, counting READ_LATENCY cycles.
REQ-026 io_read_value SHALL be sampled at the edge ending cycle (strobe cycle + READ_LATENCY); with READ_LATENCY = 0, sampling SHALL occur at the edge ending the strobe cycle and WAIT_READ SHALL be skipped.
REQ-027 At the sample edge, SHALL load rsp_data, set rsp_valid, and enter RESPOND.
REQ-028 In RESPOND, rsp_valid and rsp_data SHALL hold stable until an edge with rsp_ready high, then rsp_valid clears and the FSM returns to IDLE; no new IO strobe SHALL issue while in RESPOND.
REQ-029 io_address and io_write_value SHALL hold their last values when idle; io_write_value SHALL be unchanged by reads.
REQ-030 Commands SHALL complete strictly in FIFO order.
REQ-031 A push SHALL be accepted while the FSM is in any state; pointer wrap-around SHALL be modulo FIFO_DEPTH with a separate count or extra pointer bit for full/empty.

Reset
REQ-032 While rst is high at an edge, the block SHALL empty the FIFO, enter IDLE, and drive cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, io_address=0, io_write_value=0, io_write_en=0, io_read_en=0.
REQ-033 Reset mid-operation SHALL abort any in-flight read with no response produced and discard all queued commands.

Verification
REQ-034 Write: push write addr 0x0000, data 0xA5A5 -> io_write_en high exactly one cycle, 1 cycle after accept, with io_address=0x0000 and io_write_value=0xA5A5; no rsp_valid.
REQ-035 Read, READ_LATENCY=0: io_read_value=0x1234, push read 0x0001 -> single io_read_en pulse, then rsp_valid=1 with rsp_data=0x1234 held until rsp_ready.
REQ-036 Read, READ_LATENCY=2: io_read_value changes from 0x1111 to 0x2222 exactly 2 cycles after the strobe -> rsp_data=0x2222.
REQ-037 Full/backpressure: hold rsp_ready=0 and push 1 read then 4 writes -> cmd_ready low after the 4th write is queued (FIFO full, read in flight), no strobes while in RESPOND; releasing rsp_ready drains the 4 writes in order, 2 cycles apart.
REQ-038 Reset mid-read: assert rst during WAIT_READ -> rsp_valid stays 0, busy=0, cmd_ready=1 on the next cycle, no further strobes.
